// File: rtl/proc_mem_arbiter.sv
// Two-port arbiter sharing one single-ported word memory between the
// TinyRV1 fetch port (0) and data port (1); responses return one cycle later.
module proc_mem_arbiter #(
  parameter bit p_rr_enable = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic                    req0_wen,
  input  logic [31:0]             req0_addr,
  input  logic [31:0]             req0_wdata,
  output logic                    resp0_val,
  output logic [31:0]             resp0_data,

  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic                    req1_wen,
  input  logic [31:0]             req1_addr,
  input  logic [31:0]             req1_wdata,
  output logic                    resp1_val,
  output logic [31:0]             resp1_data,

  output logic                    mem_val,
  output logic                    mem_wen,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);

  localparam int unsigned DW = 32;

  logic prio_q,      prio_d;
  logic resp_pend_q, resp_pend_d;
  logic resp_port_q, resp_port_d;
  logic resp_wen_q,  resp_wen_d;

  logic gnt0, gnt1;

  // Grant: single requester wins outright; contention resolved by prio or port 0
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_val && req1_val) begin
        if (p_rr_enable && prio_q) gnt1 = 1'b1;
        else                       gnt0 = 1'b1;
      end else begin
        gnt0 = req0_val;
        gnt1 = req1_val;
      end
    end
  end

  assign req0_rdy = gnt0;
  assign req1_rdy = gnt1;

  // Zero-latency pass-through of the winner's request onto the memory port
  always_comb begin
    mem_val   = gnt0 | gnt1;
    mem_wen   = 1'b0;
    mem_addr  = req0_addr;
    mem_wdata = req0_wdata;
    if (gnt0) begin
      mem_wen = req0_wen;
    end else if (gnt1) begin
      mem_wen   = req1_wen;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end
  end

  always_comb begin
    prio_d      = prio_q;
    resp_pend_d = 1'b0;
    resp_port_d = resp_port_q;
    resp_wen_d  = resp_wen_q;
    if (gnt0 || gnt1) begin
      prio_d      = gnt0;
      resp_pend_d = 1'b1;
      resp_port_d = gnt1;
      resp_wen_d  = mem_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      resp_pend_q <= 1'b0;
      resp_port_q <= 1'b0;
      resp_wen_q  <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      resp_pend_q <= resp_pend_d;
      resp_port_q <= resp_port_d;
      resp_wen_q  <= resp_wen_d;
    end
  end

  // A response still pending while reset is held is dropped, never presented
  always_comb begin
    resp0_val  = resp_pend_q && !resp_port_q && !rst;
    resp1_val  = resp_pend_q &&  resp_port_q && !rst;
    resp0_data = (resp0_val && !resp_wen_q) ? mem_rdata : DW'(0);
    resp1_data = (resp1_val && !resp_wen_q) ? mem_rdata : DW'(0);
  end

endmodule
